// File: rtl/imm_encoder_pkg.sv
// Shared types and constants for the RV32 R/I/S/B instruction encoder.
// Optional feature macro: ROUNDTRIP_CHECK_EN (adds immediate re-extraction helper).
package imm_encoder_pkg;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_S = 2'd2,
        FMT_B = 2'd3
    } fmt_e;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;

`ifdef ROUNDTRIP_CHECK_EN
    function automatic logic [31:0] imm_extract(input logic [1:0] fmt,
                                                input logic [31:0] w);
        logic [31:0] v;
        v = '0;
        case (fmt_e'(fmt))
            FMT_I:   v = {{20{w[31]}}, w[31:20]};
            FMT_S:   v = {{20{w[31]}}, w[31:25], w[11:7]};
            FMT_B:   v = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: v = '0;
        endcase
        return v;
    endfunction
`endif

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational field packer for R/I/S/B words with immediate range flag.
// Range limits come from the shared package; R format never flags.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        range_err
);

    logic lo12;
    logic hi12;
    logic lo13;
    logic hi13;

    assign lo12 = $signed(imm) < IMM12_MIN;
    assign hi12 = $signed(imm) > IMM12_MAX;
    assign lo13 = $signed(imm) < IMM13_MIN;
    assign hi13 = $signed(imm) > IMM13_MAX;

    // pack fields by format and flag immediates that do not fit
    always_comb begin
        instr     = '0;
        range_err = 1'b0;
        unique case (fmt_e'(fmt))
            FMT_R: begin
                instr = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            FMT_I: begin
                instr     = {imm[11:0], rs1, funct3, rd, opcode};
                range_err = lo12 | hi12;
            end
            FMT_S: begin
                instr     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_err = lo12 | hi12;
            end
            FMT_B: begin
                instr     = {imm[12], imm[10:5], rs2, rs1, funct3,
                             imm[4:1], imm[11], opcode};
                range_err = lo13 | hi13 | imm[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready encoder: S1 range check + pack, S2 output register.
// Optional feature macro: ROUNDTRIP_CHECK_EN (sticky rt_fail_o checker).
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ERR_CNT_W = 8
) (
`ifdef ROUNDTRIP_CHECK_EN
    output logic                 rt_fail_o,
`endif
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [1:0]           fmt_i,
    input  logic [6:0]           opcode_i,
    input  logic [4:0]           rd_i,
    input  logic [4:0]           rs1_i,
    input  logic [4:0]           rs2_i,
    input  logic [2:0]           funct3_i,
    input  logic [6:0]           funct7_i,
    input  logic [31:0]          imm_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [31:0]          out_instr_o,
    output logic [ADDR_W-1:0]    out_addr_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    logic        live;
    logic        s1_valid;
    logic [31:0] s1_instr;
    logic [31:0] pk_instr;
    logic        pk_err;
    logic        s2_load;
    logic        accept;

    imm_pack u_pack (
        .fmt       (fmt_i),
        .opcode    (opcode_i),
        .rd        (rd_i),
        .rs1       (rs1_i),
        .rs2       (rs2_i),
        .funct3    (funct3_i),
        .funct7    (funct7_i),
        .imm       (imm_i),
        .instr     (pk_instr),
        .range_err (pk_err)
    );

    assign s2_load    = !out_valid_o | out_ready_i;
    assign in_ready_o = live & (!s1_valid | s2_load) & !clr_i;
    assign accept     = in_valid_i & in_ready_o;

    // hold off the input handshake until the first edge after reset release
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) live <= 1'b0;
        else        live <= 1'b1;
    end

    // S1: capture packed word of an in-range bundle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
        end else if (clr_i) begin
            s1_valid <= 1'b0;
        end else if (accept && !pk_err) begin
            s1_valid <= 1'b1;
            s1_instr <= pk_instr;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: output register, held while the consumer stalls
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_valid_o <= 1'b0;
            out_instr_o <= '0;
        end else if (clr_i) begin
            out_valid_o <= 1'b0;
        end else if (s2_load) begin
            out_valid_o <= s1_valid;
            if (s1_valid) out_instr_o <= s1_instr;
        end
    end

    // write address advances by one word per completed output handshake
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                         out_addr_o <= BASE_ADDR;
        else if (clr_i)                     out_addr_o <= BASE_ADDR;
        else if (out_valid_o && out_ready_i) out_addr_o <= out_addr_o + ADDR_W'(4);
    end

    // reject pulse and saturating reject counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            err_o <= accept & pk_err;
            if (accept && pk_err && err_cnt_o != '1)
                err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
        end
    end

`ifdef ROUNDTRIP_CHECK_EN
    logic [31:0] s1_imm;
    logic [1:0]  s1_fmt;
    logic [31:0] s2_imm;
    logic [1:0]  s2_fmt;

    // shadow the immediate and format alongside the packed word
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_imm <= '0;
            s1_fmt <= '0;
            s2_imm <= '0;
            s2_fmt <= '0;
        end else begin
            if (accept && !pk_err) begin
                s1_imm <= imm_i;
                s1_fmt <= fmt_i;
            end
            if (!clr_i && s2_load && s1_valid) begin
                s2_imm <= s1_imm;
                s2_fmt <= s1_fmt;
            end
        end
    end

    // sticky flag when the emitted word does not decode back to its immediate
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            rt_fail_o <= 1'b0;
        else if (clr_i)
            rt_fail_o <= 1'b0;
        else if (out_valid_o && fmt_e'(s2_fmt) != FMT_R &&
                 imm_extract(s2_fmt, out_instr_o) != s2_imm)
            rt_fail_o <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder with an arithmetic reference model and scoreboard.
// Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clr_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  fmt_i;
    logic [6:0]  opcode_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [31:0] out_addr_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;
`ifdef ROUNDTRIP_CHECK_EN
    logic        rt_fail_o;
`endif

    imm_encoder dut (
`ifdef ROUNDTRIP_CHECK_EN
        .rt_fail_o   (rt_fail_o),
`endif
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (clr_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .fmt_i       (fmt_i),
        .opcode_i    (opcode_i),
        .rd_i        (rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .funct3_i    (funct3_i),
        .funct7_i    (funct7_i),
        .imm_i       (imm_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_instr_o (out_instr_o),
        .out_addr_o  (out_addr_o),
        .err_o       (err_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // reference encoding built from field arithmetic
    function automatic logic [31:0] m_encode(input int f, input int op,
        input int rd, input int rs1, input int rs2, input int f3,
        input int f7, input int imm);
        int u;
        int base;
        u    = imm;
        base = rs1 * (2 ** 15) + f3 * (2 ** 12) + op;
        case (f)
            0: return 32'(f7 * (2 ** 25) + rs2 * (2 ** 20) + base
                          + rd * (2 ** 7));
            1: return 32'(((u & 'hFFF) << 20) + base + rd * (2 ** 7));
            2: return 32'((((u >> 5) & 'h7F) << 25) + rs2 * (2 ** 20)
                          + base + ((u & 'h1F) << 7));
            default: return 32'((((u >> 12) & 1) << 31)
                          + (((u >> 5) & 'h3F) << 25) + rs2 * (2 ** 20)
                          + base + (((u >> 1) & 'hF) << 8)
                          + (((u >> 11) & 1) << 7));
        endcase
    endfunction

    function automatic bit m_legal(input int f, input int imm);
        case (f)
            0: return 1'b1;
            1, 2: return imm >= -2048 && imm <= 2047;
            default: return imm >= -4096 && imm <= 4094 && (imm % 2) == 0;
        endcase
    endfunction

    logic [31:0] exp_q[$];
    logic [31:0] m_addr;
    logic        m_err;
    int          m_cnt;

    // model bookkeeping on pre-edge values
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exp_q.delete();
            m_addr = 32'h0;
            m_err  = 1'b0;
            m_cnt  = 0;
        end else if (clr_i) begin
            exp_q.delete();
            m_addr = 32'h0;
            m_err  = 1'b0;
        end else begin
            if (out_valid_o && out_ready_i && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                m_addr = m_addr + 32'd4;
            end
            m_err = 1'b0;
            if (in_valid_i && in_ready_o) begin
                if (m_legal(int'(fmt_i), int'($signed(imm_i))))
                    exp_q.push_back(m_encode(int'(fmt_i), int'(opcode_i),
                        int'(rd_i), int'(rs1_i), int'(rs2_i),
                        int'(funct3_i), int'(funct7_i),
                        int'($signed(imm_i))));
                else begin
                    m_err = 1'b1;
                    if (m_cnt != 255) m_cnt++;
                end
            end
        end
    end

    logic        stall_prev = 1'b0;
    logic [31:0] instr_prev;
    logic [31:0] addr_prev;

    // compare DUT against the model every active cycle
    always @(negedge clk_i) begin
        if (rst_i) begin
            chk("err_o", 32'(err_o), 32'(m_err));
            chk("err_cnt", 32'(err_cnt_o), 32'(m_cnt));
`ifdef ROUNDTRIP_CHECK_EN
            chk("rt_fail", 32'(rt_fail_o), 32'h0);
`endif
            if (stall_prev && out_valid_o) begin
                chk("hold_instr", out_instr_o, instr_prev);
                chk("hold_addr", out_addr_o, addr_prev);
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_word", 32'(out_valid_o), 32'h0);
                end else begin
                    chk("instr", out_instr_o, exp_q[0]);
                    chk("addr", out_addr_o, m_addr);
                end
            end
            stall_prev = out_valid_o && !out_ready_i && !clr_i;
            instr_prev = out_instr_o;
            addr_prev  = out_addr_o;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic drive(input logic [1:0] f, input logic [6:0] op,
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        fmt_i = f; opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm;
        in_valid_i = 1'b1;
    endtask

    // hold the current bundle until the handshake completes
    task automatic wait_accept();
        logic r;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            r = in_ready_o;
            @(posedge clk_i);
            #1;
            if (r) return;
        end
        chk("accept_timeout", 32'(in_ready_o), 32'h1);
    endtask

    task automatic send(input logic [1:0] f, input logic [6:0] op,
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        drive(f, op, rd, rs1, rs2, f3, f7, imm);
        wait_accept();
    endtask

    task automatic idle(input int n);
        in_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic drain();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            @(posedge clk_i);
            #1;
        end
        idle(3);
        chk("drained", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        rst_i = 1'b0; clr_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        fmt_i = '0; opcode_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
        funct3_i = '0; funct7_i = '0; imm_i = '0;

        chk("pin_R", m_encode(0, 'h33, 3, 1, 2, 0, 0, 0), 32'h002081B3);
        chk("pin_I", m_encode(1, 'h13, 1, 0, 0, 0, 0, -1), 32'hFFF00093);
        chk("pin_S", m_encode(2, 'h23, 0, 1, 2, 2, 0, 8), 32'h0020A423);
        chk("pin_B", m_encode(3, 'h63, 0, 0, 0, 0, 0, -4), 32'hFE000EE3);
        chk("pin_B_odd", 32'(m_legal(3, -3)), 32'h0);
        chk("pin_I_hi", 32'(m_legal(1, 2048)), 32'h0);

        repeat (2) @(negedge clk_i);
        chk("rst_valid", 32'(out_valid_o), 32'h0);
        chk("rst_instr", out_instr_o, 32'h0);
        chk("rst_addr", out_addr_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_cnt", 32'(err_cnt_o), 32'h0);
        chk("rst_ready", 32'(in_ready_o), 32'h0);

        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("ready_after_rst", 32'(in_ready_o), 32'h1);
        @(posedge clk_i); #1;

        send(FMT_R, OP_R, 3, 1, 2, 0, 0, 0);
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("lat_not_yet", 32'(out_valid_o), 32'h0);
        @(negedge clk_i);
        chk("lat_valid", 32'(out_valid_o), 32'h1);
        chk("add_instr", out_instr_o, 32'h002081B3);
        chk("add_addr", out_addr_o, 32'h0);
        @(posedge clk_i); #1;

        send(FMT_I, OP_I, 1, 0, 0, 0, 0, 32'hFFFF_FFFF);
        send(FMT_S, OP_S, 0, 1, 2, 2, 0, 32'd8);
        send(FMT_B, OP_B, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
        send(FMT_I, OP_I, 5, 6, 0, 3, 0, 32'd2047);
        send(FMT_S, OP_S, 0, 7, 9, 1, 0, 32'hFFFF_F800);
        send(FMT_B, OP_B, 0, 4, 5, 1, 0, 32'd4094);
        send(FMT_B, OP_B, 0, 4, 5, 5, 0, 32'hFFFF_F000);
        send(FMT_R, OP_R, 31, 30, 29, 7, 7'h20, 32'h1234_5678);
        idle(4);

        send(FMT_B, OP_B, 0, 0, 0, 0, 0, 32'hFFFF_FFFD);
        send(FMT_B, OP_B, 0, 0, 0, 0, 0, 32'd4096);
        send(FMT_I, OP_I, 1, 0, 0, 0, 0, 32'd2048);
        send(FMT_S, OP_S, 0, 1, 2, 2, 0, 32'hFFFF_F7FF);
        idle(3);
        chk("cnt_after_4", 32'(err_cnt_o), 32'd4);
        chk("no_out_on_err", 32'(out_valid_o), 32'h0);

        for (int i = 0; i < 256; i++)
            send(FMT_I, OP_I, 1, 0, 0, 0, 0, 32'd2048);
        idle(3);
        chk("cnt_sat", 32'(err_cnt_o), 32'hFF);

        out_ready_i = 1'b0;
        send(FMT_I, OP_I, 2, 0, 0, 0, 0, 32'd1);
        send(FMT_I, OP_I, 3, 0, 0, 0, 0, 32'd2);
        drive(FMT_I, OP_I, 4, 0, 0, 0, 0, 32'd3);
        repeat (5) begin
            @(negedge clk_i);
            chk("bp_ready_low", 32'(in_ready_o), 32'h0);
            @(posedge clk_i); #1;
        end
        out_ready_i = 1'b1;
        wait_accept();
        drain();

        out_ready_i = 1'b0;
        send(FMT_R, OP_R, 1, 2, 3, 0, 0, 0);
        send(FMT_R, OP_R, 4, 5, 6, 0, 0, 0);
        drive(FMT_R, OP_R, 7, 8, 9, 0, 0, 0);
        clr_i = 1'b1;
        @(negedge clk_i);
        chk("clr_ready", 32'(in_ready_o), 32'h0);
        @(posedge clk_i); #1;
        clr_i = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        chk("clr_valid", 32'(out_valid_o), 32'h0);
        chk("clr_addr", out_addr_o, 32'h0);
        idle(3);
        chk("clr_no_out", 32'(out_valid_o), 32'h0);
        send(FMT_I, OP_I, 1, 0, 0, 0, 0, 32'd5);
        in_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("post_clr_addr", out_addr_o, 32'h0);
        chk("post_clr_instr", out_instr_o, 32'h00500093);
        drain();

        out_ready_i = 1'b0;
        send(FMT_R, OP_R, 1, 1, 1, 0, 0, 0);
        send(FMT_R, OP_R, 2, 2, 2, 0, 0, 0);
        in_valid_i = 1'b0;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_mid_valid", 32'(out_valid_o), 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        out_ready_i = 1'b1;
        idle(4);
        chk("rst_mid_none", 32'(out_valid_o), 32'h0);
        chk("rst_mid_addr", out_addr_o, 32'h0);
        send(FMT_S, OP_S, 0, 3, 4, 2, 0, 32'd12);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
